// File: rtl/rgb_rx_pkg.sv
// Shared types and widths for the RGB stream receiver.
package rgb_rx_pkg;

  localparam int PIXEL_W = 24;
  localparam int COORD_W = 16;

  // One buffered pixel with its frame coordinates.
  typedef struct packed {
    logic [PIXEL_W-1:0] data;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } rx_entry_t;

  localparam int ENTRY_W = $bits(rx_entry_t);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LINE  = 3'd1,
    GAP   = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } rx_state_t;

endpackage

// File: rtl/rgb_rx_fifo.sv
// First-word fall-through synchronous FIFO. DEPTH must be a power of two
// (>= 2) so the pointers wrap on their own; count disambiguates full/empty.
// A push while full is accepted only when a pop happens in the same cycle.
module rgb_rx_fifo #(
  parameter int ENTRY_W = 56,
  parameter int DEPTH   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [ENTRY_W-1:0]       wr_data,
  output logic [ENTRY_W-1:0]       rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; reset flushes the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/rgb_stream_receiver.sv
// Receiving end of the horizontal_sync/r/g/b pixel stream. Tags each pixel
// with (x,y), buffers it in a FWFT FIFO and flags malformed lines/overflow.
// Optional build macro RGB_RX_CHECKSUM_EN adds a running r+g+b checksum port.
//
//   state | meaning
//   IDLE  | waiting for the first pixel of the frame
//   LINE  | horizontal_sync high, capturing pixels
//   GAP   | between lines
//   FLUSH | all lines received, FIFO still draining
//   DONE  | frame complete, input ignored until reset
module rgb_stream_receiver
  import rgb_rx_pkg::*;
#(
  parameter int WIDTH      = 768,
  parameter int HEIGHT     = 512,
  parameter int FIFO_DEPTH = 16
) (
  input  logic               horizontal_clock,
  input  logic               horizontal_reset,
  input  logic               horizontal_sync,
  input  logic [7:0]         r,
  input  logic [7:0]         g,
  input  logic [7:0]         b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PIXEL_W-1:0] out_data,
  output logic [COORD_W-1:0] out_x,
  output logic [COORD_W-1:0] out_y,
  output logic               out_sof,
  output logic               out_eol,
  output logic               frame_done,
  output logic               overflow,
  output logic               line_len_err
`ifdef RGB_RX_CHECKSUM_EN
  ,
  output logic [31:0]        checksum
`endif
);

  localparam int CW1 = COORD_W + 1;
  localparam logic [COORD_W-1:0] WIDTH_C  = COORD_W'(WIDTH);
  localparam logic [CW1-1:0]     HEIGHT_C = CW1'(HEIGHT);

  rx_state_t            state;
  logic [COORD_W-1:0]   col;
  logic [COORD_W-1:0]   row;
  logic                 capture;
  logic                 in_range;
  logic                 push;
  logic                 pop;
  logic                 last_line;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic [ENTRY_W-1:0]   rd_data;
  rx_entry_t            wr_entry;
  rx_entry_t            head;

  assign capture   = horizontal_sync &
                     ((state == IDLE) | (state == LINE) | (state == GAP));
  assign in_range  = (col < WIDTH_C);
  assign push      = capture & in_range;
  assign pop       = out_valid & out_ready;
  assign last_line = (({1'b0, row} + CW1'(1)) >= HEIGHT_C);

  assign wr_entry  = '{data: {r, g, b}, x: col, y: row};

  rgb_rx_fifo #(
    .ENTRY_W (ENTRY_W),
    .DEPTH   (FIFO_DEPTH)
  ) u_fifo (
    .clk     (horizontal_clock),
    .rst     (horizontal_reset),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_entry),
    .rd_data (rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Head-entry presentation; zeroed when nothing is buffered.
  assign head      = rx_entry_t'(rd_data);
  assign out_valid = (fifo_count != '0);
  assign out_data  = out_valid ? head.data : '0;
  assign out_x     = out_valid ? head.x : '0;
  assign out_y     = out_valid ? head.y : '0;
  assign out_sof   = out_valid & (head.x == '0) & (head.y == '0);
  assign out_eol   = out_valid & (head.x == WIDTH_C - COORD_W'(1));

  // Frame FSM with column/row counters and sticky status flags.
  always_ff @(posedge horizontal_clock) begin
    if (horizontal_reset) begin
      state        <= IDLE;
      col          <= '0;
      row          <= '0;
      overflow     <= 1'b0;
      line_len_err <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      if (capture) begin
        // Column still advances on an overflow drop so tags stay aligned.
        if (in_range) col <= col + COORD_W'(1);
        else          line_len_err <= 1'b1;
      end
      if (push & fifo_full & ~pop) overflow <= 1'b1;

      case (state)
        IDLE, GAP: begin
          if (horizontal_sync) state <= LINE;
        end
        LINE: begin
          if (!horizontal_sync) begin
            if (col != WIDTH_C) line_len_err <= 1'b1;
            col   <= '0;
            row   <= row + COORD_W'(1);
            state <= last_line ? FLUSH : GAP;
          end
        end
        FLUSH: begin
          if (fifo_empty) begin
            state      <= DONE;
            frame_done <= 1'b1;
          end
        end
        default: begin
          state <= DONE;
        end
      endcase
    end
  end

`ifdef RGB_RX_CHECKSUM_EN
  // Running sum of every in-range captured pixel, including overflow drops.
  always_ff @(posedge horizontal_clock) begin
    if (horizontal_reset) begin
      checksum <= '0;
    end else if (push) begin
      checksum <= checksum + 32'(r) + 32'(g) + 32'(b);
    end
  end
`endif

endmodule

// File: tb/tb_rgb_stream_receiver.sv
// Directed bench for rgb_stream_receiver with WIDTH=4, HEIGHT=2, FIFO_DEPTH=4.
module tb_rgb_stream_receiver;

  localparam int W = 4;
  localparam int H = 2;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hs = 1'b0;
  logic [7:0]  r = '0, g = '0, b = '0;
  logic        ready = 1'b0;
  logic        out_valid;
  logic [23:0] out_data;
  logic [15:0] out_x, out_y;
  logic        out_sof, out_eol, frame_done, overflow, line_len_err;
`ifdef RGB_RX_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit const_pix = 1'b0;

  always #5 clk = ~clk;

  rgb_stream_receiver #(
    .WIDTH      (W),
    .HEIGHT     (H),
    .FIFO_DEPTH (D)
  ) dut (
    .horizontal_clock (clk),
    .horizontal_reset (rst),
    .horizontal_sync  (hs),
    .r                (r),
    .g                (g),
    .b                (b),
    .out_valid        (out_valid),
    .out_ready        (ready),
    .out_data         (out_data),
    .out_x            (out_x),
    .out_y            (out_y),
    .out_sof          (out_sof),
    .out_eol          (out_eol),
    .frame_done       (frame_done),
    .overflow         (overflow),
    .line_len_err     (line_len_err)
`ifdef RGB_RX_CHECKSUM_EN
    ,
    .checksum         (checksum)
`endif
  );

  function automatic logic [23:0] pix(input int x, input int y);
    if (const_pix) return 24'h010203;
    return {8'(x + 1), 8'(8'h40 + y), 8'h5A};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input int x, input int y);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_x"},     32'(out_x), 32'(x));
    chk({tag, "_y"},     32'(out_y), 32'(y));
    chk({tag, "_data"},  32'(out_data), 32'(pix(x, y)));
    chk({tag, "_sof"},   32'(out_sof), 32'(x == 0 && y == 0));
    chk({tag, "_eol"},   32'(out_eol), 32'(x == W - 1));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    hs  = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic send(input int x, input int y);
    hs = 1'b1;
    {r, g, b} = pix(x, y);
    tick();
  endtask

  task automatic idle(input int n);
    hs = 1'b0;
    repeat (n) tick();
  endtask

  // Well-formed frame with out_ready=1: each pixel visible one edge after capture.
  task automatic run_nominal(input string tag);
    ready = 1'b1;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        send(x, y);
        chk_head($sformatf("%s_p%0d%0d", tag, x, y), x, y);
      end
      hs = 1'b0;
      tick();
      chk($sformatf("%s_gap_valid%0d", tag, y), 32'(out_valid), 32'd0);
      if (y < H - 1) begin
        idle(2);
      end else begin
        chk({tag, "_done_early"}, 32'(frame_done), 32'd0);
        tick();
        chk({tag, "_done"}, 32'(frame_done), 32'd1);
      end
    end
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
    chk({tag, "_lle"}, 32'(line_len_err), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    do_reset();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data",  32'(out_data), 32'd0);
    chk("rst_done",  32'(frame_done), 32'd0);
    chk("rst_ovf",   32'(overflow), 32'd0);
    chk("rst_lle",   32'(line_len_err), 32'd0);

    // Nominal frame, then input ignored in DONE
    run_nominal("nom");
    send(0, 0);
    send(1, 0);
    hs = 1'b0;
    tick();
    chk("done_ign_valid", 32'(out_valid), 32'd0);
    chk("done_ign_done",  32'(frame_done), 32'd1);
    chk("done_ign_lle",   32'(line_len_err), 32'd0);
    chk("done_ign_ovf",   32'(overflow), 32'd0);

    // Backpressure: only line 0 survives
    do_reset();
    ready = 1'b0;
    for (int x = 0; x < W; x++) begin
      send(x, 0);
      chk_head($sformatf("bp_hold%0d", x), 0, 0);
    end
    chk("bp_ovf_before", 32'(overflow), 32'd0);
    idle(3);
    send(0, 1);
    chk("bp_ovf_set", 32'(overflow), 32'd1);
    for (int x = 1; x < W; x++) send(x, 1);
    hs = 1'b0;
    tick();
    chk("bp_not_done", 32'(frame_done), 32'd0);
    ready = 1'b1;
    for (int k = 0; k < W; k++) begin
      chk_head($sformatf("bp_drain%0d", k), k, 0);
      tick();
    end
    chk("bp_empty", 32'(out_valid), 32'd0);
    chk("bp_done_early", 32'(frame_done), 32'd0);
    tick();
    chk("bp_done", 32'(frame_done), 32'd1);
    chk("bp_lle", 32'(line_len_err), 32'd0);
    chk("bp_ovf_sticky", 32'(overflow), 32'd1);

    // Full FIFO with simultaneous push and pop
    do_reset();
    ready = 1'b0;
    for (int x = 0; x < W; x++) send(x, 0);
    idle(3);
    ready = 1'b1;
    for (int x = 0; x < W; x++) begin
      send(x, 1);
      chk_head($sformatf("pp_head%0d", x), (x + 1) % W, (x + 1) / W);
      chk($sformatf("pp_ovf%0d", x), 32'(overflow), 32'd0);
    end
    hs = 1'b0;
    tick();
    for (int j = 5; j < 8; j++) begin
      chk_head($sformatf("pp_drain%0d", j), j % W, j / W);
      tick();
    end
    chk("pp_empty", 32'(out_valid), 32'd0);
    tick();
    chk("pp_done", 32'(frame_done), 32'd1);
    chk("pp_ovf_end", 32'(overflow), 32'd0);

    // Malformed lines: 3 pixels, then 6 pixels
    do_reset();
    ready = 1'b1;
    for (int x = 0; x < 3; x++) begin
      send(x, 0);
      chk_head($sformatf("ml_l0_%0d", x), x, 0);
    end
    chk("ml_lle_before", 32'(line_len_err), 32'd0);
    hs = 1'b0;
    tick();
    chk("ml_lle_short", 32'(line_len_err), 32'd1);
    idle(2);
    for (int x = 0; x < 6; x++) begin
      send(x, 1);
      if (x < W) chk_head($sformatf("ml_l1_%0d", x), x, 1);
      else       chk($sformatf("ml_drop%0d", x), 32'(out_valid), 32'd0);
    end
    hs = 1'b0;
    tick();
    chk("ml_not_done", 32'(frame_done), 32'd0);
    tick();
    chk("ml_done", 32'(frame_done), 32'd1);
    chk("ml_lle", 32'(line_len_err), 32'd1);
    chk("ml_ovf", 32'(overflow), 32'd0);

    // Reset mid-frame after 5 pixels, then a clean frame
    do_reset();
    ready = 1'b0;
    for (int x = 0; x < W; x++) send(x, 0);
    idle(1);
    send(0, 1);
    chk("mr_ovf_pre", 32'(overflow), 32'd1);
    rst = 1'b1;
    hs  = 1'b0;
    tick();
    rst = 1'b0;
    chk("mr_valid", 32'(out_valid), 32'd0);
    chk("mr_ovf",   32'(overflow), 32'd0);
    chk("mr_lle",   32'(line_len_err), 32'd0);
    chk("mr_done",  32'(frame_done), 32'd0);
    run_nominal("mr");

`ifdef RGB_RX_CHECKSUM_EN
    // Checksum: 8 pixels of 1+2+3
    do_reset();
    const_pix = 1'b1;
    chk("cks_rst", checksum, 32'd0);
    run_nominal("cks");
    chk("cks_sum", checksum, 32'd48);
    send(0, 0);
    send(1, 0);
    hs = 1'b0;
    tick();
    chk("cks_hold", checksum, 32'd48);
    const_pix = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rgb_stream_receiver.md
Name: rgb_stream_receiver

Overview:
- Receiving end of the horizontal_sync/r/g/b pixel stream produced by the image reader.
- Counts columns and rows against the configured image size and buffers pixels in a small FIFO.
- Presents each pixel on a valid/ready bus with x/y coordinates and frame markers, for the resize datapath.
- Flags malformed lines and FIFO overflow, and signals frame completion.

Parameters:
- WIDTH, 768: pixels per line.
- HEIGHT, 512: lines per frame.
- FIFO_DEPTH, 16: pixel FIFO entries; must be a power of 2 and at least 2.

Ports:
- horizontal_clock  in  1  sole clock; all logic on the rising edge.
- horizontal_reset  in  1  synchronous, active-high reset.
- horizontal_sync  in  1  high on each cycle carrying a valid pixel of the current line.
- r / g / b  in  8 each  pixel components, valid when horizontal_sync=1.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  consumer accepts the head this cycle.
- out_data  out  24  {r,g,b} of the head.
- out_x  out  16  column of the head.
- out_y  out  16  row of the head.
- out_sof  out  1  head is pixel (0,0).
- out_eol  out  1  head has x = WIDTH-1.
- frame_done  out  1  all HEIGHT lines received and FIFO drained.
- overflow  out  1  sticky: a pixel was dropped because the FIFO was full.
- line_len_err  out  1  sticky: a line ended with a pixel count other than WIDTH.

Behaviour:
- Reset: on horizontal_reset=1 at an edge, all outputs go to 0 and the FIFO is flushed. col, row and state are cleared, including mid-frame.
- States:
  - IDLE: waits for the first horizontal_sync=1.
  - LINE: horizontal_sync high.
  - GAP: between lines.
  - FLUSH: all lines received, FIFO not yet empty.
  - DONE.
- Transitions:
  - IDLE→LINE and GAP→LINE on horizontal_sync=1; that cycle's pixel is captured.
  - LINE→GAP on horizontal_sync falling with row+1 < HEIGHT.
  - LINE→FLUSH on horizontal_sync falling with row+1 = HEIGHT.
  - FLUSH→DONE when the FIFO is empty.
  - DONE is held until reset; frame_done=1 only in DONE.
- Capture in LINE (including the entry cycle): the pixel is pushed with tag (col,row).
  - col increments while col < WIDTH.
  - If col ≥ WIDTH, the pixel is dropped and line_len_err is set.
- Line end (horizontal_sync falling): if col ≠ WIDTH, line_len_err is set. Then col←0 and row←row+1.
- After DONE: horizontal_sync is ignored, with no push and no flag update.
- FIFO: first-word fall-through.
  - out_valid = ~empty; out_* are driven from the head entry.
  - Pop when out_valid & out_ready.
  - Write-to-out_valid latency is 1 cycle: a pixel sampled at edge N is visible after edge N.
  - Push and pop in the same cycle are both honoured, including when full (count unchanged).
  - Push when full with no pop: the pixel is dropped, overflow is set, and col still increments so coordinates stay correct.
  - out_ready while out_valid=0 has no effect.
- Arithmetic: col/row counters are 16 bits wide; WIDTH and HEIGHT must each be ≤ 65535. Pointers are log2(FIFO_DEPTH) bits and wrap naturally; an extra count register distinguishes full from empty.
- out_sof = (out_x==0 && out_y==0). out_eol = (out_x==WIDTH-1). Both are qualified by out_valid.

Optional Feature:
- Macro RGB_RX_CHECKSUM_EN.
- Defined: adds output port checksum [31:0].
  - Every captured pixel (pushed or dropped for overflow, but not a col ≥ WIDTH drop) adds r+g+b, zero-extended.
  - The sum wraps modulo 2^32, resets to 0, and freezes in DONE.
- Not defined: no port, no adder, no register.

Decomposition:
- Package rgb_rx_pkg holds:
  - PIXEL_W=24 and COORD_W=16.
  - Typedef for the FIFO entry {data, x, y}.
  - State enum {IDLE, LINE, GAP, FLUSH, DONE}.
- Sub-module rgb_rx_fifo: parameterised FWFT synchronous FIFO (entry width, depth) exposing full, empty and count. The top holds the FSM, counters and flags.

Test Plan:
- Nominal frame (WIDTH=4, HEIGHT=2, FIFO_DEPTH=4, out_ready=1): two lines of 4 pixels, 3-cycle gap.
  - Expect 8 pixels out, each 1 cycle after capture, with out_x 0..3 and out_y 0,1.
  - out_sof only on the first pixel; out_eol on x=3.
  - frame_done=1 after the last pop; both flags 0.
- Backpressure: same frame with out_ready=0 throughout.
  - 4 pixels buffered; the 5th–8th are dropped and overflow=1.
  - Releasing out_ready yields exactly the pixels (0,0)..(3,0); frame_done follows.
- Full simultaneous push/pop: FIFO full, out_ready=1 while pixels continue to arrive.
  - No drop and overflow stays 0; count stays 4.
- Malformed lines: line 0 has 3 pixels, line 1 has 6 pixels.
  - line_len_err=1; pixels x=4,5 of line 1 are not output; the frame still reaches DONE.
- Reset mid-frame: assert horizontal_reset for 1 cycle after 5 pixels.
  - out_valid=0, flags 0 and counters 0 the next cycle.
  - A following full frame is received correctly starting at (0,0).
- Checksum (macro defined): frame of all pixels r=1, g=2, b=3 with WIDTH=4, HEIGHT=2.
  - checksum=48, holds after DONE.
